rail_fence_param_core: RTL and testbench

Parametrised rail-fence cipher engine, successor to the fixed 256-bit/2-rail decipher core in the Lab2 datapath. It accepts one DATA_W-bit block and processes one column (RAILS bits) per cycle. It supports both decrypt (cipher→plain) and encrypt (plain→cipher) modes. It sits between the block-capture logic and the result/display stage, with the same start/finished handshake as the existing cores.

---
 rtl/rail_fence_param_core.sv | 120 ++++++++++++
 tb/tb_rail_fence_param_core.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rail_fence_param_core.sv
// Parametrised rail-fence cipher engine, one column of RAILS bits per cycle.
// Optional abort input enabled by defining RAILFENCE_ABORT_EN.
module rail_fence_param_core #(
  parameter int DATA_W = 256,
  parameter int RAILS  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_new,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
`ifdef RAILFENCE_ABORT_EN
  input  logic              i_abort,
`endif
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_finished
);

  localparam int L  = DATA_W / RAILS;
  localparam int CW = $clog2(L);
  localparam int IW = $clog2(DATA_W);

  typedef enum logic {
    S_IDLE,
    S_CALC
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     col;
  logic [CW-1:0]     col_nxt;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              mode_r;
  logic              mode_nxt;
  logic              fin_nxt;
  logic              abort;
  logic              last;
  logic [IW-1:0]     col_x;
  logic [IW-1:0]     row_idx [RAILS];
  logic [IW-1:0]     col_idx [RAILS];

`ifdef RAILFENCE_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  assign last   = (col == CW'(L - 1));
  assign col_x  = IW'(col);
  assign o_busy = (state == S_CALC);

  // row_idx = r*L+col (rail-major), col_idx = RAILS*col+r (column-major)
  for (genvar r = 0; r < RAILS; r++) begin : g_idx
    assign row_idx[r] = IW'(r * L) + col_x;
    assign col_idx[r] = IW'(RAILS) * col_x + IW'(r);
  end

  always_ff @(posedge i_clk or negedge i_rst_new) begin
    if (!i_rst_new) begin
      state      <= S_IDLE;
      col        <= '0;
      in_r       <= '0;
      mode_r     <= 1'b0;
      o_data     <= '0;
      o_finished <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      in_r       <= in_nxt;
      mode_r     <= mode_nxt;
      o_data     <= data_nxt;
      o_finished <= fin_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    in_nxt    = in_r;
    mode_nxt  = mode_r;
    data_nxt  = o_data;
    fin_nxt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          in_nxt    = i_data;
          mode_nxt  = i_mode;
          data_nxt  = '0;
          col_nxt   = '0;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        for (int r = 0; r < RAILS; r++) begin
          if (mode_r) begin
            data_nxt[col_idx[r]] = in_r[row_idx[r]];
          end else begin
            data_nxt[row_idx[r]] = in_r[col_idx[r]];
          end
        end
        // abort takes priority over completing the last column
        if (abort) begin
          state_nxt = S_IDLE;
          col_nxt   = '0;
        end else if (last) begin
          state_nxt = S_IDLE;
          col_nxt   = '0;
          fin_nxt   = 1'b1;
        end else begin
          col_nxt = col + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rail_fence_param_core.sv
// Bench for rail_fence_param_core: nine parameter sets, scoreboard checking.
// Abort scenario runs only when RAILFENCE_ABORT_EN is defined.
module tb_rail_fence_param_core;

  localparam int NI = 9;

  function automatic int dw_of(input int g);
    case (g)
      0: return 256;
      1: return 16;
      2: return 16;
      3: return 16;
      4: return 64;
      5: return 64;
      6: return 64;
      7: return 256;
      default: return 256;
    endcase
  endfunction

  function automatic int rails_of(input int g);
    case (g)
      0: return 2;
      1: return 4;
      2: return 2;
      3: return 8;
      4: return 2;
      5: return 4;
      6: return 8;
      7: return 4;
      default: return 8;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_s [NI];
  logic         mode_s  [NI];
  logic [255:0] din_s   [NI];
  logic [255:0] dout_s  [NI];
  logic         busy_s  [NI];
  logic         fin_s   [NI];
`ifdef RAILFENCE_ABORT_EN
  logic         abort_s [NI];
`endif

  int errors = 0;
  int checks = 0;
  logic [255:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = dw_of(g);
    localparam int RL = rails_of(g);
    logic [DW-1:0] q;
    rail_fence_param_core #(
      .DATA_W(DW),
      .RAILS (RL)
    ) u_dut (
      .i_clk     (clk),
      .i_rst_new (rst_n),
      .i_start   (start_s[g]),
      .i_mode    (mode_s[g]),
      .i_data    (din_s[g][DW-1:0]),
`ifdef RAILFENCE_ABORT_EN
      .i_abort   (abort_s[g]),
`endif
      .o_data    (q),
      .o_busy    (busy_s[g]),
      .o_finished(fin_s[g])
    );
    assign dout_s[g] = 256'(q);
  end

  function automatic logic [255:0] model(input int g, input logic m,
                                         input logic [255:0] x);
    int rl = rails_of(g);
    int l = dw_of(g) / rails_of(g);
    logic [255:0] y = '0;
    for (int r = 0; r < rl; r++) begin
      for (int k = 0; k < l; k++) begin
        if (!m) y[r*l+k] = x[rl*k+r];
        else    y[rl*k+r] = x[r*l+k];
      end
    end
    return y;
  endfunction

  function automatic logic [255:0] mask_of(input int g);
    logic [255:0] m = '0;
    for (int i = 0; i < dw_of(g); i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic start_blk(input int g, input logic m, input logic [255:0] x);
    exp_q.push_back(model(g, m, x));
    start_s[g] = 1'b1;
    mode_s[g]  = m;
    din_s[g]   = x;
    @(posedge clk);
    @(negedge clk);
    start_s[g] = 1'b0;
  endtask

  task automatic wait_fin(input int g, input int k0, input string name,
                          output logic [255:0] res);
    int k = k0;
    int l = dw_of(g) / rails_of(g);
    logic [255:0] exp;
    while (!fin_s[g] && k < l + 8) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != l) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, k, l);
    end
    checks++;
    if (busy_s[g] !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_with_fin: got %b want 0", name, busy_s[g]);
    end
    res = dout_s[g];
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue want entry", name);
    end else begin
      exp = exp_q.pop_front();
      if (res !== exp) begin
        errors++;
        $display("FAIL %s data: got %h want %h", name, res, exp);
      end
    end
  endtask

  task automatic check_fin_drop(input int g, input string name);
    @(negedge clk);
    checks++;
    if (fin_s[g] !== 1'b0) begin
      errors++;
      $display("FAIL %s fin_drop: got %b want 0", name, fin_s[g]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b0;
      mode_s[g]  = 1'b0;
      din_s[g]   = '0;
`ifdef RAILFENCE_ABORT_EN
      abort_s[g] = 1'b0;
`endif
    end
    #12;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (dout_s[g] !== '0 || busy_s[g] !== 1'b0 || fin_s[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got data=%h busy=%b fin=%b want 0/0/0",
                 g, dout_s[g], busy_s[g], fin_s[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_2rail();
    logic [255:0] x;
    logic [255:0] res;
    logic [255:0] want;
    x = {128{2'b10}};
    want = {{128{1'b1}}, 128'h0};
    start_blk(0, 1'b0, x);
    checks++;
    if (busy_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL r2 busy: got %b want 1", busy_s[0]);
    end
    wait_fin(0, 0, "r2_dec", res);
    checks++;
    if (res !== want) begin
      errors++;
      $display("FAIL r2_const: got %h want %h", res, want);
    end
    check_fin_drop(0, "r2_dec");
    checks++;
    if (dout_s[0] !== want) begin
      errors++;
      $display("FAIL r2_hold: got %h want %h", dout_s[0], want);
    end
  endtask

  task automatic test_4rail();
    logic [255:0] res;
    start_blk(1, 1'b0, 256'h000F);
    wait_fin(1, 0, "r4_dec", res);
    checks++;
    if (res !== 256'h1111) begin
      errors++;
      $display("FAIL r4_dec_const: got %h want 1111", res);
    end
    check_fin_drop(1, "r4_dec");
    start_blk(1, 1'b1, 256'h1111);
    wait_fin(1, 0, "r4_enc", res);
    checks++;
    if (res !== 256'h000F) begin
      errors++;
      $display("FAIL r4_enc_const: got %h want 000f", res);
    end
    check_fin_drop(1, "r4_enc");
  endtask

  task automatic test_back_to_back();
    logic [255:0] res;
    start_blk(1, 1'b0, 256'h000F);
    @(negedge clk);
    @(negedge clk);
    start_s[1] = 1'b1;
    mode_s[1]  = 1'b1;
    din_s[1]   = 256'hFFFF;
    @(posedge clk);
    @(negedge clk);
    start_s[1] = 1'b0;
    wait_fin(1, 3, "ignore_start", res);
    checks++;
    if (res !== 256'h1111) begin
      errors++;
      $display("FAIL ignore_start_const: got %h want 1111", res);
    end
    start_blk(1, 1'b1, 256'h1111);
    checks++;
    if (fin_s[1] !== 1'b0 || busy_s[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got fin=%b busy=%b want 0/1",
               fin_s[1], busy_s[1]);
    end
    wait_fin(1, 0, "b2b", res);
    check_fin_drop(1, "b2b");
  endtask

  task automatic test_reset_mid();
    bit saw_fin = 1'b0;
    start_blk(1, 1'b0, 256'hFFFF);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dout_s[1] !== 256'h3333) begin
      errors++;
      $display("FAIL partial_pre_reset: got %h want 3333", dout_s[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_s[1] !== '0 || busy_s[1] !== 1'b0 || fin_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got data=%h busy=%b fin=%b want 0/0/0",
               dout_s[1], busy_s[1], fin_s[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fin_s[1] || busy_s[1]) saw_fin = 1'b1;
    end
    checks++;
    if (saw_fin) begin
      errors++;
      $display("FAIL reset_mid_no_pulse: got activity want none");
    end
  endtask

`ifdef RAILFENCE_ABORT_EN
  task automatic test_abort();
    bit saw_fin = 1'b0;
    start_blk(1, 1'b0, 256'hFFFF);
    void'(exp_q.pop_back());
    @(negedge clk);
    abort_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_s[1] = 1'b0;
    checks++;
    if (busy_s[1] !== 1'b0 || dout_s[1] !== 256'h3333) begin
      errors++;
      $display("FAIL abort: got busy=%b data=%h want 0/3333",
               busy_s[1], dout_s[1]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fin_s[1]) saw_fin = 1'b1;
    end
    checks++;
    if (saw_fin || dout_s[1] !== 256'h3333) begin
      errors++;
      $display("FAIL abort_hold: got pulse=%b data=%h want 0/3333",
               saw_fin, dout_s[1]);
    end
  endtask
`endif

  task automatic test_sweep();
    logic [255:0] x;
    logic [255:0] c;
    logic [255:0] p;
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 8; i++) x[i*32+:32] = $urandom;
      x = x & mask_of(g);
      start_blk(g, 1'b1, x);
      wait_fin(g, 0, $sformatf("sweep_enc%0d", g), c);
      start_blk(g, 1'b0, c);
      wait_fin(g, 0, $sformatf("sweep_dec%0d", g), p);
      checks++;
      if (p !== x) begin
        errors++;
        $display("FAIL sweep_roundtrip%0d: got %h want %h", g, p, x);
      end
      check_fin_drop(g, $sformatf("sweep%0d", g));
    end
  endtask

  initial begin
    test_reset();
    test_2rail();
    test_4rail();
    test_back_to_back();
    test_reset_mid();
`ifdef RAILFENCE_ABORT_EN
    test_abort();
`endif
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
